// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and the synchroniser depth
// default, used by both the read and the write pointer controllers.
package fifo_pkg;

  // Default number of flops in a pointer synchroniser chain.
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // Width the conversion helpers operate on; callers zero-extend and truncate.
  localparam int unsigned PTR_FN_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [PTR_FN_W-1:0] bin2gray(input logic [PTR_FN_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code to binary: each binary bit is the XOR of all Gray bits above and at it.
  function automatic logic [PTR_FN_W-1:0] gray2bin(input logic [PTR_FN_W-1:0] gray);
    logic [PTR_FN_W-1:0] bin;
    bin = gray;
    for (int unsigned i = 1; i < PTR_FN_W; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_bus.sv
// Multi-flop synchroniser for a Gray-coded bus; every stage clears on reset.
module sync_bus
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the bus through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: synchronises the write pointer,
// owns the read pointer, drives the RAM read port and produces status flags.
// FWFT=1 prefetches the head word so it is presented before rd_en acknowledges it.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter int unsigned FWFT          = 0
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  input  logic                  rd_en,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0] wr_gray_s;
  logic [PTR_W-1:0] wr_bin_s;

  logic [PTR_W-1:0] rd_bin_q,   rd_bin_d;
  logic [PTR_W-1:0] rd_gray_q,  rd_gray_d;
  logic [PTR_W-1:0] count_q,    count_d;
  logic             fe_q,       fe_d;
  logic             empty_q,    empty_d;
  logic             aempty_q,   aempty_d;
  logic             rd_valid_q, rd_valid_d;
  logic             uflow_q,    uflow_d;
  logic             pop;

  // Bring the write pointer into the read clock domain.
  sync_bus #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk   (rd_clk),
    .rst_n (rst_n),
    .d_i   (wr_ptr_gray),
    .q_o   (wr_gray_s)
  );

  assign wr_bin_s = PTR_W'(gray2bin(PTR_FN_W'(wr_gray_s)));

  // Pop decision, next pointer and next-state flags (flags use the post-pop pointer).
  always_comb begin
    pop        = 1'b0;
    rd_bin_d   = rd_bin_q;
    rd_gray_d  = rd_gray_q;
    fe_d       = fe_q;
    count_d    = count_q;
    aempty_d   = aempty_q;
    rd_valid_d = rd_valid_q;
    empty_d    = empty_q;
    uflow_d    = 1'b0;

    if (FWFT != 0) begin
      pop = ~fe_q & (~rd_valid_q | rd_en);
    end else begin
      pop = rd_en & ~fe_q;
    end
    // No RAM access while reset is held.
    pop = pop & rst_n;

    rd_bin_d  = rd_bin_q + PTR_W'(pop);
    rd_gray_d = PTR_W'(bin2gray(PTR_FN_W'(rd_bin_d)));
    fe_d      = (rd_gray_d == wr_gray_s);
    count_d   = wr_bin_s - rd_bin_d;
    aempty_d  = (count_d <= AE_TH);

    if (FWFT != 0) begin
      // Presented word stays until acknowledged; a prefetch refills it in the same edge.
      if (pop) begin
        rd_valid_d = 1'b1;
      end else if (rd_en && rd_valid_q) begin
        rd_valid_d = 1'b0;
      end
      empty_d = ~rd_valid_d;
      uflow_d = rd_en & ~rd_valid_q;
    end else begin
      // RAM returns data one cycle after the read enable.
      rd_valid_d = pop;
      empty_d    = fe_d;
      uflow_d    = rd_en & fe_q;
    end
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      rd_bin_q   <= '0;
      rd_gray_q  <= '0;
      count_q    <= '0;
      fe_q       <= 1'b1;
      empty_q    <= 1'b1;
      aempty_q   <= 1'b1;
      rd_valid_q <= 1'b0;
      uflow_q    <= 1'b0;
    end else begin
      rd_bin_q   <= rd_bin_d;
      rd_gray_q  <= rd_gray_d;
      count_q    <= count_d;
      fe_q       <= fe_d;
      empty_q    <= empty_d;
      aempty_q   <= aempty_d;
      rd_valid_q <= rd_valid_d;
      uflow_q    <= uflow_d;
    end
  end

  assign ram_ren      = pop;
  assign ram_raddr    = rd_bin_q[ADDR_WIDTH-1:0];
  assign rd_ptr_gray  = rd_gray_q;
  assign rd_valid     = rd_valid_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign rd_count     = count_q;
  assign underflow    = uflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: one standard-read and one FWFT instance.
module tb_fifo_rd_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] wr0, wr1;
  logic       rd_en0, rd_en1;

  logic       ren0, vld0, emp0, ae0, uf0;
  logic [3:0] raddr0;
  logic [4:0] rpg0, cnt0;
  logic       ren1, vld1, emp1, ae1, uf1;
  logic [3:0] raddr1;
  logic [4:0] rpg1, cnt1;

  int n_cmp;
  int n_err;

  fifo_rd_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .AEMPTY_THRESH(2), .FWFT(0)) dut0 (
    .rd_clk(clk), .rst_n(rst_n), .wr_ptr_gray(wr0), .rd_en(rd_en0),
    .ram_ren(ren0), .ram_raddr(raddr0), .rd_ptr_gray(rpg0), .rd_valid(vld0),
    .empty(emp0), .almost_empty(ae0), .rd_count(cnt0), .underflow(uf0)
  );

  fifo_rd_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .AEMPTY_THRESH(2), .FWFT(1)) dut1 (
    .rd_clk(clk), .rst_n(rst_n), .wr_ptr_gray(wr1), .rd_en(rd_en1),
    .ram_ren(ren1), .ram_raddr(raddr1), .rd_ptr_gray(rpg1), .rd_valid(vld1),
    .empty(emp1), .almost_empty(ae1), .rd_count(cnt1), .underflow(uf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [4:0] g5(input int unsigned b);
    return 5'(b ^ (b >> 1));
  endfunction

  // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    rd_en0 = 1'b0;
    rd_en1 = 1'b0;
    wr0    = '0;
    wr1    = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_emp"}, 32'(emp0), 1);
    chk({tag, "_ae"},  32'(ae0),  1);
    chk({tag, "_cnt"}, 32'(cnt0), 0);
    chk({tag, "_vld"}, 32'(vld0), 0);
    chk({tag, "_uf"},  32'(uf0),  0);
    chk({tag, "_rpg"}, 32'(rpg0), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset values on both instances; ram_ren must stay low even with rd_en asserted.
    do_reset();
    rst_n  = 1'b0;
    rd_en0 = 1'b1;
    rd_en1 = 1'b1;
    tick();
    chk_reset0("rst0");
    chk("rst1_emp", 32'(emp1), 1);
    chk("rst1_vld", 32'(vld1), 0);
    chk("rst1_cnt", 32'(cnt1), 0);
    chk("rst_ren0", 32'(ren0), 0);
    chk("rst_ren1", 32'(ren1), 0);

    // One word arrives: empty falls three edges later.
    do_reset();
    wr0 = g5(1);
    tick();
    chk("w1_emp_e1", 32'(emp0), 1);
    tick();
    chk("w1_emp_e2", 32'(emp0), 1);
    tick();
    chk("w1_emp_e3", 32'(emp0), 0);
    chk("w1_cnt", 32'(cnt0), 1);
    chk("w1_ae", 32'(ae0), 1);

    // Pop at count=1 in the same edge the next write pointer reaches the sync output.
    wr0 = g5(2);
    tick();
    tick();
    rd_en0 = 1'b1;
    #1;
    chk("sim_ren", 32'(ren0), 1);
    chk("sim_raddr", 32'(raddr0), 0);
    tick();
    rd_en0 = 1'b0;
    chk("sim_cnt", 32'(cnt0), 1);
    chk("sim_emp", 32'(emp0), 0);
    chk("sim_vld", 32'(vld0), 1);
    chk("sim_rpg", 32'(rpg0), 32'(g5(1)));
    rd_en0 = 1'b1;
    tick();
    chk("sim_drain_cnt", 32'(cnt0), 0);
    chk("sim_drain_emp", 32'(emp0), 1);
    tick();
    chk("sim_uf", 32'(uf0), 1);
    chk("sim_uf_vld", 32'(vld0), 0);
    chk("sim_uf_rpg", 32'(rpg0), 32'(g5(2)));
    rd_en0 = 1'b0;
    tick();
    chk("sim_uf_clr", 32'(uf0), 0);

    // Five words, rd_en held six cycles.
    do_reset();
    wr0 = g5(5);
    repeat (3) tick();
    chk("r5_cnt", 32'(cnt0), 5);
    chk("r5_ae", 32'(ae0), 0);
    chk("r5_emp", 32'(emp0), 0);
    for (int k = 0; k < 6; k++) begin
      rd_en0 = 1'b1;
      #1;
      chk($sformatf("r5_ren%0d", k), 32'(ren0), (k < 5) ? 1 : 0);
      if (k < 5) chk($sformatf("r5_raddr%0d", k), 32'(raddr0), k);
      tick();
      chk($sformatf("r5_vld%0d", k), 32'(vld0), (k < 5) ? 1 : 0);
      chk($sformatf("r5_cnt%0d", k), 32'(cnt0), (k < 5) ? (4 - k) : 0);
      chk($sformatf("r5_emp%0d", k), 32'(emp0), (k >= 4) ? 1 : 0);
      chk($sformatf("r5_ae%0d", k), 32'(ae0), (k >= 2) ? 1 : 0);
      chk($sformatf("r5_uf%0d", k), 32'(uf0), (k == 5) ? 1 : 0);
    end
    rd_en0 = 1'b0;
    chk("r5_rpg_hold", 32'(rpg0), 32'(g5(5)));

    // Reset in the middle of a read with rd_valid=1 and rd_count=7.
    do_reset();
    wr0 = g5(8);
    repeat (3) tick();
    rd_en0 = 1'b1;
    tick();
    chk("mid_cnt", 32'(cnt0), 7);
    chk("mid_vld", 32'(vld0), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_ren", 32'(ren0), 0);
    tick();
    chk_reset0("mid");
    rd_en0 = 1'b0;

    // FWFT: three words present, one automatic prefetch, then three acknowledges.
    do_reset();
    wr1 = g5(3);
    repeat (3) tick();
    chk("fw_cnt3", 32'(cnt1), 3);
    chk("fw_emp_pre", 32'(emp1), 1);
    #1;
    chk("fw_ren_pre", 32'(ren1), 1);
    tick();
    chk("fw_vld", 32'(vld1), 1);
    chk("fw_emp", 32'(emp1), 0);
    chk("fw_cnt2", 32'(cnt1), 2);
    #1;
    chk("fw_ren_idle", 32'(ren1), 0);
    tick();
    chk("fw_cnt_idle", 32'(cnt1), 2);
    rd_en1 = 1'b1;
    tick();
    chk("fw_ack1_cnt", 32'(cnt1), 1);
    chk("fw_ack1_vld", 32'(vld1), 1);
    tick();
    chk("fw_ack2_cnt", 32'(cnt1), 0);
    chk("fw_ack2_vld", 32'(vld1), 1);
    #1;
    chk("fw_ack3_ren", 32'(ren1), 0);
    tick();
    chk("fw_ack3_vld", 32'(vld1), 0);
    chk("fw_ack3_emp", 32'(emp1), 1);
    chk("fw_ack3_uf", 32'(uf1), 0);
    tick();
    chk("fw_uf", 32'(uf1), 1);
    rd_en1 = 1'b0;
    tick();
    chk("fw_uf_clr", 32'(uf1), 0);

    // Pointer wrap: advance reader to 30, write pointer to 34 (mod 32 = 2).
    do_reset();
    wr0 = g5(16);
    repeat (3) tick();
    chk("wr_full_cnt", 32'(cnt0), 16);
    rd_en0 = 1'b1;
    repeat (16) tick();
    rd_en0 = 1'b0;
    chk("wr_p16_rpg", 32'(rpg0), 32'(g5(16)));
    wr0 = g5(30);
    repeat (3) tick();
    rd_en0 = 1'b1;
    repeat (14) tick();
    rd_en0 = 1'b0;
    chk("wr_p30_rpg", 32'(rpg0), 32'(g5(30)));
    chk("wr_p30_emp", 32'(emp0), 1);
    wr0 = g5(34 % 32);
    repeat (3) tick();
    chk("wr_cnt4", 32'(cnt0), 4);
    chk("wr_emp4", 32'(emp0), 0);
    for (int k = 0; k < 4; k++) begin
      rd_en0 = 1'b1;
      #1;
      chk($sformatf("wr_raddr%0d", k), 32'(raddr0), (14 + k) % 16);
      tick();
      chk($sformatf("wr_rpg%0d", k), 32'(rpg0), 32'(g5((31 + k) % 32)));
      chk($sformatf("wr_cnt%0d", k), 32'(cnt0), 3 - k);
      chk($sformatf("wr_emp%0d", k), 32'(emp0), (k == 3) ? 1 : 0);
    end
    rd_en0 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, RAM address width; depth DEPTH = 2**ADDR_WIDTH (power of two only).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for the write pointer; legal range 2..4.
REQ-003 SHALL have parameter AEMPTY_THRESH, default 2, almost-empty level in words; legal range 0..DEPTH-1.
REQ-004 SHALL have parameter FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-005 SHALL have ports rd_clk in 1, read clock; rst_n in 1, reset: synchronous, active-low.
REQ-006 SHALL have ports wr_ptr_gray in ADDR_WIDTH+1, write pointer in Gray code (write domain); rd_en in 1, user read request/acknowledge.
REQ-007 SHALL have ports ram_ren out 1, RAM read enable; ram_raddr out ADDR_WIDTH, RAM read address.
REQ-008 SHALL have ports rd_ptr_gray out ADDR_WIDTH+1, registered Gray read pointer to the write domain; rd_valid out 1, data at RAM output valid.
REQ-009 SHALL have ports empty out 1; almost_empty out 1; rd_count out ADDR_WIDTH+1, words held; underflow out 1, one-cycle error pulse.

Function
REQ-010 SHALL pass wr_ptr_gray through SYNC_STAGES rd_clk flops; only the last stage is used, converted Gray->binary (wr_bin_s).
REQ-011 SHALL keep rd_bin, ADDR_WIDTH+1 bits, natural modulo-2*DEPTH wrap (0..2*DEPTH-1); ram_raddr = rd_bin[ADDR_WIDTH-1:0].
REQ-012 SHALL register rd_ptr_gray = next_rd_bin ^ (next_rd_bin >> 1), updated in the same edge as rd_bin; exactly one bit changes per pop.
REQ-013 SHALL define the internal pop as ram_ren; on pop, rd_bin increments by 1, else holds.
REQ-014 SHALL register the internal FIFO-empty flag fe = (next_rd_gray == synchronised wr gray); wr updates are visible SYNC_STAGES+1 cycles after arrival at the port.
REQ-015 SHALL register rd_count = (wr_bin_s - next_rd_bin) mod 2**(ADDR_WIDTH+1); range 0..DEPTH.
REQ-016 SHALL register almost_empty = (count <= AEMPTY_THRESH), computed from the same next-state count.
REQ-017 With FWFT=0: ram_ren = rd_en & ~fe (combinational); empty = fe; rd_valid = ram_ren delayed one cycle (RAM latency 1).
REQ-018 With FWFT=0: underflow SHALL pulse for one cycle, one cycle after rd_en & fe; pointer unchanged.
REQ-019 With FWFT=1: ram_ren = ~fe & (~rd_valid | rd_en) (prefetch); rd_valid SET on the edge after ram_ren, CLEARED on the edge where rd_en & rd_valid & ~ram_ren.
REQ-020 With FWFT=1: empty = ~rd_valid; rd_en with rd_valid consumes the presented word; underflow pulses one cycle after rd_en & ~rd_valid.
REQ-021 Simultaneous pop and pointer arrival SHALL both apply; count/flags use post-pop and post-sync values in the same edge.
REQ-022 Wrap 2*DEPTH-1 -> 0 SHALL be seamless: no flag glitch, count correct across the wrap.

Reset
REQ-023 On rst_n=0 at a rd_clk edge: rd_bin=0, rd_ptr_gray=0, all sync flops=0, empty=1, almost_empty=1, rd_count=0, rd_valid=0, underflow=0.
REQ-024 ram_ren SHALL be 0 while rst_n=0; reset mid-read discards any in-flight word (rd_valid=0 next cycle).
REQ-025 The first pop is allowed no earlier than the second edge after rst_n rises and the synchronised pointer becomes non-equal.

Structure
REQ-026 Shared package fifo_pkg SHALL hold bin2gray/gray2bin functions and SYNC_STAGES default; reused by the write controller.
REQ-027 Sub-module sync_bus (parameterised width/stages, reset to 0) SHALL implement REQ-010; no other hierarchy.

Verification
REQ-028 Reset, then wr_ptr_gray 0->1 (1 word): empty falls SYNC_STAGES+1 cycles later; rd_count=1; almost_empty=1.
REQ-029 FWFT=0, wr_ptr_gray=Gray(5), rd_en held 6 cycles: ram_raddr 0..4, five rd_valid pulses, empty=1 after 5th, underflow at 6th.
REQ-030 FWFT=1, 3 words present, rd_en low: one auto prefetch, rd_valid=1, empty=0, rd_count=2; three rd_en acks -> rd_valid=0.
REQ-031 Wrap: write pointer advanced to 34 (Gray), reader drains from 30 -> rd_bin goes 31->0->1->2; rd_count decrements 4,3,2,1,0, no glitch.
REQ-032 rst_n asserted with rd_valid=1 and rd_count=7: next cycle all outputs at REQ-023 values.
REQ-033 rd_en and wr pointer +1 on the same cycle at count=1: count stays 1, empty stays 0.
